cache_controller: RTL and testbench

Two-way set-associative, write-through, read-allocate data cache between the MIPS memory stage and the SRAM controller. It answers read hits with zero stall, forwards every miss and write to the SRAM controller, and drives `ready` low to freeze the pipeline while an SRAM access is outstanding. The memory stage sees the same `rd_en`/`wr_en`/`ready` contract it would see from the SRAM controller directly.

---
 rtl/cache_controller.sv | 245 ++++++++++++++++++++++++
 tb/tb_cache_controller.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_controller.sv
// ---------------------------------------------------------------------------------------------
// cache_controller
//
// Two-way set-associative, write-through, read-allocate data cache sitting between the MIPS
// memory stage and the SRAM controller. Read hits complete in the request cycle. Read misses
// and all writes are forwarded to the SRAM controller while o_ready is held low to freeze the
// pipeline. The memory stage sees the same rd/wr/ready contract as the bare SRAM controller.
//
// Ports:
//   clk                clock, rising edge
//   rst                asynchronous, active-high reset
//   i_rd_en            memory-stage read request, held until o_ready
//   i_wr_en            memory-stage write request, held until o_ready (read wins if both set)
//   i_addr             byte address; index = addr[7:2], tag = addr[17:8] (defaults)
//   i_write_data       store data
//   o_read_data        load result, valid when i_rd_en and o_ready are both 1
//   o_ready            0 freezes the pipeline
//   o_sram_rd_en       read request to the SRAM controller
//   o_sram_wr_en       write request to the SRAM controller
//   o_sram_addr        i_addr passed through
//   o_sram_write_data  i_write_data passed through
//   i_sram_read_data   SRAM controller read result
//   i_sram_ready       SRAM controller ready (stale in the cycle a request is issued)
// ---------------------------------------------------------------------------------------------
module cache_controller #(
    parameter int unsigned SETS  = 64,
    parameter int unsigned TAG_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_rd_en,
    input  logic        i_wr_en,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_write_data,
    output logic [31:0] o_read_data,
    output logic        o_ready,
    output logic        o_sram_rd_en,
    output logic        o_sram_wr_en,
    output logic [31:0] o_sram_addr,
    output logic [31:0] o_sram_write_data,
    input  logic [31:0] i_sram_read_data,
    input  logic        i_sram_ready
);

    localparam int unsigned IDX_W   = $clog2(SETS);
    localparam int unsigned TAG_LSB = IDX_W + 2;

    typedef enum logic [1:0] {
        StIdle,
        StRdWait,
        StWrWait
    } state_e;

    state_e r_state;
    state_e w_state_next;

    // Per-way storage. Valid and LRU bits are reset; tags and words are qualified by valid.
    logic [SETS-1:0]  r_valid0;
    logic [SETS-1:0]  r_valid1;
    logic [SETS-1:0]  r_lru;      // way to evict next
    logic [TAG_W-1:0] r_tag0  [SETS];
    logic [TAG_W-1:0] r_tag1  [SETS];
    logic [31:0]      r_data0 [SETS];
    logic [31:0]      r_data1 [SETS];

    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic             w_hit0;
    logic             w_hit1;
    logic             w_hit;
    logic             w_hit_way;
    logic [31:0]      w_hit_data;
    logic             w_victim;

    logic             w_fill_en;
    logic             w_wr_hit_en;
    logic             w_lru_we;
    logic             w_lru_val;

    // Address bits outside the index/tag fields are deliberately ignored.
    logic             w_unused_addr;

    assign w_idx         = i_addr[IDX_W+1:2];
    assign w_tag         = i_addr[TAG_LSB+TAG_W-1:TAG_LSB];
    assign w_unused_addr = ^{i_addr[31:TAG_LSB+TAG_W], i_addr[1:0]};

    assign o_sram_addr       = i_addr;
    assign o_sram_write_data = i_write_data;

    // Hit detection. Both ways never hold the same tag, so way0 taking precedence is harmless.
    assign w_hit0     = r_valid0[w_idx] && (r_tag0[w_idx] == w_tag);
    assign w_hit1     = r_valid1[w_idx] && (r_tag1[w_idx] == w_tag);
    assign w_hit      = w_hit0 || w_hit1;
    assign w_hit_way  = !w_hit0 && w_hit1;
    assign w_hit_data = w_hit_way ? r_data1[w_idx] : r_data0[w_idx];

    // Victim: fill empty ways first, otherwise follow LRU.
    always_comb begin
        if (!r_valid0[w_idx]) begin
            w_victim = 1'b0;
        end else if (!r_valid1[w_idx]) begin
            w_victim = 1'b1;
        end else begin
            w_victim = r_lru[w_idx];
        end
    end

    // -----------------------------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Next state, outputs and storage write enables
    // -----------------------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        o_ready      = 1'b1;
        o_read_data  = 32'h0;
        o_sram_rd_en = 1'b0;
        o_sram_wr_en = 1'b0;
        w_fill_en    = 1'b0;
        w_wr_hit_en  = 1'b0;
        w_lru_we     = 1'b0;
        w_lru_val    = 1'b0;

        unique case (r_state)
            StIdle: begin
                // i_sram_ready is stale here, so it is not looked at.
                if (i_rd_en) begin
                    if (w_hit) begin
                        o_read_data = w_hit_data;
                        w_lru_we    = 1'b1;
                        w_lru_val   = ~w_hit_way;
                    end else begin
                        o_ready      = 1'b0;
                        o_sram_rd_en = 1'b1;
                        w_state_next = StRdWait;
                    end
                end else if (i_wr_en) begin
                    o_ready      = 1'b0;
                    o_sram_wr_en = 1'b1;
                    w_state_next = StWrWait;
                    // Write-through: update a cached copy, never allocate on a write miss.
                    if (w_hit) begin
                        w_wr_hit_en = 1'b1;
                        w_lru_we    = 1'b1;
                        w_lru_val   = ~w_hit_way;
                    end
                end
            end

            StRdWait: begin
                if (i_sram_ready) begin
                    // Bypass the returning word and fill the victim on the same edge.
                    o_read_data  = i_sram_read_data;
                    w_fill_en    = 1'b1;
                    w_lru_we     = 1'b1;
                    w_lru_val    = ~w_victim;
                    w_state_next = StIdle;
                end else begin
                    o_ready      = 1'b0;
                    o_sram_rd_en = 1'b1;
                end
            end

            StWrWait: begin
                // Drop the enable as soon as ready is seen so no second access starts.
                o_sram_wr_en = !i_sram_ready;
                o_ready      = i_sram_ready;
                if (i_sram_ready) begin
                    w_state_next = StIdle;
                end
            end

            default: begin
                w_state_next = StIdle;
            end
        endcase

        // Reset dominates: quiet outputs and no storage updates, even with a request held.
        if (rst) begin
            w_state_next = StIdle;
            o_ready      = 1'b1;
            o_read_data  = 32'h0;
            o_sram_rd_en = 1'b0;
            o_sram_wr_en = 1'b0;
            w_fill_en    = 1'b0;
            w_wr_hit_en  = 1'b0;
            w_lru_we     = 1'b0;
            w_lru_val    = 1'b0;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Valid and LRU bits
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid0 <= '0;
            r_valid1 <= '0;
            r_lru    <= '0;
        end else begin
            if (w_fill_en) begin
                if (w_victim) begin
                    r_valid1[w_idx] <= 1'b1;
                end else begin
                    r_valid0[w_idx] <= 1'b1;
                end
            end
            if (w_lru_we) begin
                r_lru[w_idx] <= w_lru_val;
            end
        end
    end

    // -----------------------------------------------------------------------------------------
    // Tags and data words
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_fill_en) begin
            if (w_victim) begin
                r_tag1[w_idx]  <= w_tag;
                r_data1[w_idx] <= i_sram_read_data;
            end else begin
                r_tag0[w_idx]  <= w_tag;
                r_data0[w_idx] <= i_sram_read_data;
            end
        end
        if (w_wr_hit_en) begin
            if (w_hit_way) begin
                r_data1[w_idx] <= i_write_data;
            end else begin
                r_data0[w_idx] <= i_write_data;
            end
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// ---------------------------------------------------------------------------------------------
// tb_cache_controller
//
// Self-checking bench for cache_controller. A behavioural 6-count SRAM controller answers the
// cache; expected load data and stall lengths are pushed to a scoreboard queue when a request
// is driven and popped when the cache raises ready.
// ---------------------------------------------------------------------------------------------
module tb_cache_controller;

    logic        clk;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] read_data;
    logic        ready;
    logic        sram_rd_en;
    logic        sram_wr_en;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        sram_ready;

    cache_controller #(
        .SETS  (64),
        .TAG_W (10)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .i_rd_en           (rd_en),
        .i_wr_en           (wr_en),
        .i_addr            (addr),
        .i_write_data      (wdata),
        .o_read_data       (read_data),
        .o_ready           (ready),
        .o_sram_rd_en      (sram_rd_en),
        .o_sram_wr_en      (sram_wr_en),
        .o_sram_addr       (sram_addr),
        .o_sram_write_data (sram_wdata),
        .i_sram_read_data  (sram_rdata),
        .i_sram_ready      (sram_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_pass;

    typedef struct {
        logic [31:0] data;
        int          stall;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_mem  [logic [31:0]];
    logic [31:0] sram_mem [logic [31:0]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Initial memory image shared in value (not storage) by the SRAM model and the reference.
    function automatic logic [31:0] init_word(input logic [31:0] a);
        if (a == 32'h40) return 32'hDEADBEEF;
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        if (exp_mem.exists(a)) return exp_mem[a];
        return init_word(a);
    endfunction

    // 6-count SRAM controller: ready is 0 after edges 1-5 of an access and 1 after edge 6.
    int          m_cnt;
    logic        m_busy;
    logic [31:0] m_addr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy     <= 1'b0;
            m_cnt      <= 0;
            m_addr     <= 32'h0;
            sram_ready <= 1'b1;
            sram_rdata <= 32'h0;
        end else if (!m_busy) begin
            if (sram_rd_en || sram_wr_en) begin
                m_busy     <= 1'b1;
                m_cnt      <= 1;
                sram_ready <= 1'b0;
                m_addr     <= sram_addr;
                if (sram_wr_en) sram_mem[sram_addr] = sram_wdata;
            end
        end else begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == 5) begin
                m_busy     <= 1'b0;
                sram_ready <= 1'b1;
                sram_rdata <= sram_mem.exists(m_addr) ? sram_mem[m_addr] : init_word(m_addr);
            end
        end
    end

    // Drive one request and follow it until ready; exp_stall is 0 for a hit, 6 otherwise.
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input int exp_stall);
        exp_t e;
        int   stall;
        bit   done;
        e.data  = rd ? exp_word(a) : 32'h0;
        e.stall = exp_stall;
        if (!rd && wr) exp_mem[a] = d;
        sb.push_back(e);

        @(posedge clk);
        #1;
        rd_en = rd;
        wr_en = wr;
        addr  = a;
        wdata = d;
        stall = 0;
        done  = 1'b0;
        while (!done) begin
            @(negedge clk);
            check("ready", 32'(ready), 32'(stall == exp_stall));
            check("sram_rd_en", 32'(sram_rd_en), 32'(rd && stall < exp_stall));
            check("sram_wr_en", 32'(sram_wr_en), 32'(!rd && wr && stall < exp_stall));
            if (stall == 0) begin
                check("sram_addr", sram_addr, a);
                check("sram_write_data", sram_wdata, d);
            end
            if (ready) begin
                done = 1'b1;
            end else begin
                stall++;
                if (stall > 20) begin
                    check("ready_timeout", 32'd1, 32'd0);
                    done = 1'b1;
                end
            end
        end
        e = sb.pop_front();
        if (rd) check("read_data", read_data, e.data);
        check("stall_cycles", 32'(stall), 32'(e.stall));

        @(posedge clk);
        #1;
        rd_en = 1'b0;
        wr_en = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        rd_en    = 1'b1;   // a held request must not leak through during reset
        wr_en    = 1'b0;
        addr     = 32'h40;
        wdata    = 32'h0;

        #12;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_read_data", read_data, 32'h0);
        check("rst_sram_rd_en", 32'(sram_rd_en), 32'd0);
        check("rst_sram_wr_en", 32'(sram_wr_en), 32'd0);
        rd_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Cold miss then immediate hit.
        do_req(1'b1, 1'b0, 32'h040, 32'h0, 6);
        do_req(1'b1, 1'b0, 32'h040, 32'h0, 0);

        // Fill both ways of set 16, then evict by LRU.
        do_req(1'b1, 1'b0, 32'h140, 32'h0, 6);
        do_req(1'b1, 1'b0, 32'h040, 32'h0, 0);
        do_req(1'b1, 1'b0, 32'h240, 32'h0, 6);   // evicts 0x140 from way1
        do_req(1'b1, 1'b0, 32'h040, 32'h0, 0);
        do_req(1'b1, 1'b0, 32'h140, 32'h0, 6);   // evicts 0x240
        do_req(1'b1, 1'b0, 32'h040, 32'h0, 0);
        do_req(1'b1, 1'b0, 32'h140, 32'h0, 0);

        // Write hit then read-back hit.
        do_req(1'b0, 1'b1, 32'h040, 32'h12345678, 6);
        do_req(1'b1, 1'b0, 32'h040, 32'h0, 0);

        // Write miss does not allocate.
        do_req(1'b0, 1'b1, 32'h080, 32'hCAFEF00D, 6);
        do_req(1'b1, 1'b0, 32'h080, 32'h0, 6);
        do_req(1'b1, 1'b0, 32'h080, 32'h0, 0);

        // Read and write together: read wins and memory stays unwritten.
        do_req(1'b1, 1'b1, 32'h300, 32'h55AA55AA, 6);
        do_req(1'b1, 1'b0, 32'h300, 32'h0, 0);

        // Reset in the middle of a read miss.
        @(posedge clk);
        #1;
        rd_en = 1'b1;
        addr  = 32'h440;
        repeat (3) @(negedge clk);
        check("mid_miss_ready", 32'(ready), 32'd0);
        check("mid_miss_sram_rd_en", 32'(sram_rd_en), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid_ready", 32'(ready), 32'd1);
        check("rst_mid_sram_rd_en", 32'(sram_rd_en), 32'd0);
        check("rst_mid_sram_wr_en", 32'(sram_wr_en), 32'd0);
        check("rst_mid_read_data", read_data, 32'h0);
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Previously cached 0x40 and the abandoned 0x440 both miss after reset.
        do_req(1'b1, 1'b0, 32'h040, 32'h0, 6);
        do_req(1'b1, 1'b0, 32'h440, 32'h0, 6);
        do_req(1'b1, 1'b0, 32'h040, 32'h0, 0);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
